// File: rtl/parity_frame_receiver.sv
// parity_frame_receiver: LSB-first start/data/parity/stop deserialiser with XOR parity check (in: clock, reset, tick, serial_in; out: data_out, data_valid, parity_error, frame_error, busy)
module parity_frame_receiver #(
  parameter int DATA_BITS  = 8,
  parameter int ODD_PARITY = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_error,
  output logic                 frame_error,
  output logic                 busy
);
  localparam int CW = $clog2(DATA_BITS + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t               state_q;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CW-1:0]        cnt_q;
  logic                 acc_q, acc_d;
  assign shift_d = DATA_BITS'({serial_in, shift_q} >> 1);
  assign acc_d   = acc_q ^ serial_in;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      cnt_q        <= '0;
      acc_q        <= 1'b0;
      data_out     <= '0;
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
      if (tick) begin
        case (state_q)
          IDLE: if (!serial_in) begin
            state_q <= DATA;
            cnt_q   <= '0;
            acc_q   <= (ODD_PARITY != 0);
            busy    <= 1'b1;
          end
          DATA: begin
            shift_q <= shift_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_q + CW'(1);
            if (cnt_q == CW'(DATA_BITS - 1)) state_q <= PARITY;
          end
          PARITY: begin
            acc_q   <= acc_d;
            state_q <= STOP;
          end
          STOP: begin
            data_out     <= shift_q;
            data_valid   <= 1'b1;
            parity_error <= acc_q;
            frame_error  <= ~serial_in;
            state_q      <= IDLE;
            busy         <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_parity_frame_receiver.sv
// tb_parity_frame_receiver: scoreboard bench for even (default) and odd parity receivers
module tb_parity_frame_receiver;
  logic       clk = 1'b0, reset = 1'b1;
  logic       tick_e = 1'b0, ser_e = 1'b1, tick_o = 1'b0, ser_o = 1'b1;
  logic [7:0] dout_e, dout_o;
  logic       val_e, pe_e, fe_e, busy_e, val_o, pe_o, fe_o, busy_o;
  logic       pv_e = 1'b0, pv_o = 1'b0;
  logic [9:0] q_e[$], q_o[$];
  logic [9:0] x;
  int         n_chk = 0, n_fail = 0, bcnt = 0, blen = -1;

  parity_frame_receiver u_even (
    .clock(clk), .reset(reset), .tick(tick_e), .serial_in(ser_e),
    .data_out(dout_e), .data_valid(val_e), .parity_error(pe_e),
    .frame_error(fe_e), .busy(busy_e)
  );

  parity_frame_receiver #(.DATA_BITS(8), .ODD_PARITY(1)) u_odd (
    .clock(clk), .reset(reset), .tick(tick_o), .serial_in(ser_o),
    .data_out(dout_o), .data_valid(val_o), .parity_error(pe_o),
    .frame_error(fe_o), .busy(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit o, input bit t, input bit s);
    if (o) begin
      tick_o = t;
      ser_o  = s;
    end else begin
      tick_e = t;
      ser_e  = s;
    end
  endtask

  task automatic send_bit(input bit o, input bit b, input int sp);
    for (int i = 1; i < sp; i++) begin
      drive(o, 1'b0, 1'($urandom_range(0, 1)));
      @(posedge clk);
      #1;
    end
    drive(o, 1'b1, b);
    @(posedge clk);
    #1;
    drive(o, 1'b0, 1'b1);
  endtask

  task automatic send_frame(input bit o, input logic [7:0] d, input bit par, input bit stp, input int sp);
    send_bit(o, 1'b0, sp);
    for (int i = 0; i < 8; i++) send_bit(o, d[i], sp);
    send_bit(o, par, sp);
    send_bit(o, stp, sp);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      bcnt = 0;
    end else begin
      if (val_e) begin
        chk("even valid width", 32'(pv_e), 0);
        chk("even busy at valid", 32'(busy_e), 0);
        blen = bcnt;
        bcnt = 0;
        if (q_e.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL even unexpected valid: data %0h pe %0b fe %0b", dout_e, pe_e, fe_e);
        end else begin
          x = q_e.pop_front();
          chk("even data_out", 32'(dout_e), 32'(x[9:2]));
          chk("even parity_error", 32'(pe_e), 32'(x[1]));
          chk("even frame_error", 32'(fe_e), 32'(x[0]));
        end
      end else if (busy_e) begin
        bcnt++;
      end
      if (val_o) begin
        chk("odd valid width", 32'(pv_o), 0);
        if (q_o.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL odd unexpected valid: data %0h pe %0b fe %0b", dout_o, pe_o, fe_o);
        end else begin
          x = q_o.pop_front();
          chk("odd data_out", 32'(dout_o), 32'(x[9:2]));
          chk("odd parity_error", 32'(pe_o), 32'(x[1]));
          chk("odd frame_error", 32'(fe_o), 32'(x[0]));
        end
      end
      pv_e = val_e;
      pv_o = val_o;
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset data_out", 32'(dout_e), 0);
    chk("reset data_valid", 32'(val_e), 0);
    chk("reset parity_error", 32'(pe_e), 0);
    chk("reset frame_error", 32'(fe_e), 0);
    chk("reset busy", 32'(busy_e), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    // clean 0xA5, continuous ticks
    q_e.push_back({8'hA5, 1'b0, 1'b0});
    send_frame(1'b0, 8'hA5, 1'b0, 1'b1, 1);
    @(negedge clk);
    #1 chk("busy length continuous", 32'(blen), 10);
    // parity fault
    q_e.push_back({8'hA5, 1'b1, 1'b0});
    send_frame(1'b0, 8'hA5, 1'b1, 1'b1, 1);
    // framing fault followed with no gap by a clean frame
    q_e.push_back({8'h3C, 1'b0, 1'b1});
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1);
    q_e.push_back({8'h81, 1'b0, 1'b0});
    send_frame(1'b0, 8'h81, 1'b0, 1'b1, 1);
    // reset after start + 4 data bits of 0xFF
    send_bit(1'b0, 1'b0, 1);
    repeat (4) send_bit(1'b0, 1'b1, 1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post-reset data_out", 32'(dout_e), 0);
    chk("post-reset data_valid", 32'(val_e), 0);
    chk("post-reset parity_error", 32'(pe_e), 0);
    chk("post-reset frame_error", 32'(fe_e), 0);
    chk("post-reset busy", 32'(busy_e), 0);
    @(posedge clk);
    #1;
    q_e.push_back({8'h12, 1'b0, 1'b0});
    send_frame(1'b0, 8'h12, 1'b0, 1'b1, 1);
    // sparse ticks with noise between them
    q_e.push_back({8'h5A, 1'b0, 1'b0});
    send_frame(1'b0, 8'h5A, 1'b0, 1'b1, 5);
    @(negedge clk);
    #1 chk("busy length sparse", 32'(blen), 50);
    repeat (3) @(negedge clk);
    chk("data_out hold", 32'(dout_e), 32'h5A);
    chk("valid low after pulse", 32'(val_e), 0);
    // odd parity instance
    q_o.push_back({8'h00, 1'b0, 1'b0});
    send_frame(1'b1, 8'h00, 1'b1, 1'b1, 1);
    q_o.push_back({8'h00, 1'b1, 1'b0});
    send_frame(1'b1, 8'h00, 1'b0, 1'b1, 1);
    for (int i = 0; i < 20 && (q_e.size() + q_o.size()) != 0; i++) @(negedge clk);
    chk("scoreboard drained", 32'(q_e.size() + q_o.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
